// File: rtl/router_sync_n.sv
// Synchroniser between the router packet FSM and NUM_CH output FIFOs: address latch,
// one-hot write steering, full/valid reporting and per-channel unread-data timeout.
// Optional out-of-range address flag is enabled by defining SYNC_ADDR_CHECK_EN.
module router_sync_n #(
    parameter int NUM_CH  = 3,
    parameter int ADDR_W  = 2,
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              detect_addr,
    input  logic [ADDR_W-1:0] datain,
    input  logic              we_reg,
    input  logic [NUM_CH-1:0] re,
    input  logic [NUM_CH-1:0] empty,
    input  logic [NUM_CH-1:0] full,
    output logic              fifo_full,
    output logic [NUM_CH-1:0] we,
    output logic [NUM_CH-1:0] vld_out,
    output logic [NUM_CH-1:0] soft_reset,
    output logic              addr_err
);

    logic [ADDR_W-1:0] addr_r;
    logic              addr_vld_r;
    logic              addr_err_s;
    logic [NUM_CH-1:0] we_s;
    logic              fifo_full_s;

    // Destination address latch, loaded on the header cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_r     <= {ADDR_W{1'b0}};
            addr_vld_r <= 1'b0;
        end else if (detect_addr) begin
            addr_r     <= datain;
            addr_vld_r <= 1'b1;
        end else begin
            addr_r     <= addr_r;
            addr_vld_r <= addr_vld_r;
        end
    end

`ifdef SYNC_ADDR_CHECK_EN
    localparam logic [ADDR_W:0] NUM_CH_L = (ADDR_W+1)'(NUM_CH);
    logic addr_err_r;

    // Out-of-range flag follows each newly latched address
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_err_r <= 1'b0;
        end else if (detect_addr) begin
            addr_err_r <= ({1'b0, datain} >= NUM_CH_L);
        end else begin
            addr_err_r <= addr_err_r;
        end
    end

    assign addr_err_s = addr_err_r;
`else
    assign addr_err_s = 1'b0;
`endif

    // Address decode: an address matching no channel leaves every strobe and full low
    always_comb begin
        we_s        = {NUM_CH{1'b0}};
        fifo_full_s = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (addr_r == ADDR_W'(i)) begin
                we_s[i]     = we_reg & addr_vld_r & ~addr_err_s;
                fifo_full_s = addr_vld_r & ~addr_err_s & full[i];
            end else begin
                we_s[i]     = 1'b0;
            end
        end
    end

    assign we        = we_s;
    assign fifo_full = fifo_full_s;
    assign vld_out   = ~empty;
    assign addr_err  = addr_err_s;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] cnt_r;
        logic             pulse_r;

        // Unread-valid timeout; wraps to zero on expiry so a stalled channel re-pulses
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_r   <= {CNT_W{1'b0}};
                pulse_r <= 1'b0;
            end else if (empty[g] | re[g]) begin
                cnt_r   <= {CNT_W{1'b0}};
                pulse_r <= 1'b0;
            end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
                cnt_r   <= {CNT_W{1'b0}};
                pulse_r <= 1'b1;
            end else begin
                cnt_r   <= cnt_r + CNT_W'(1);
                pulse_r <= 1'b0;
            end
        end

        assign soft_reset[g] = pulse_r;
    end

endmodule

// File: tb/tb_router_sync_n.sv
// Directed bench for router_sync_n: a default 3-channel instance and a 5-channel,
// TIMEOUT=4 instance, checked against hand-computed vectors and timeout sequences.
module tb_router_sync_n;

`ifdef SYNC_ADDR_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       detect_addr;
    logic [1:0] datain;
    logic       we_reg;
    logic [2:0] re, empty, full;
    logic       fifo_full;
    logic [2:0] we, vld_out, soft_reset;
    logic       addr_err;

    logic       d5_detect;
    logic [2:0] d5_datain;
    logic       d5_we_reg;
    logic [4:0] d5_re, d5_empty, d5_full;
    logic       d5_fifo_full;
    logic [4:0] d5_we, d5_vld_out, d5_soft_reset;
    logic       d5_addr_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    router_sync_n u_dut (
        .clk(clk), .reset(reset), .detect_addr(detect_addr), .datain(datain),
        .we_reg(we_reg), .re(re), .empty(empty), .full(full),
        .fifo_full(fifo_full), .we(we), .vld_out(vld_out),
        .soft_reset(soft_reset), .addr_err(addr_err)
    );

    router_sync_n #(.NUM_CH(5), .ADDR_W(3), .TIMEOUT(4), .CNT_W(3)) u_dut5 (
        .clk(clk), .reset(reset), .detect_addr(d5_detect), .datain(d5_datain),
        .we_reg(d5_we_reg), .re(d5_re), .empty(d5_empty), .full(d5_full),
        .fifo_full(d5_fifo_full), .we(d5_we), .vld_out(d5_vld_out),
        .soft_reset(d5_soft_reset), .addr_err(d5_addr_err)
    );

    typedef struct {
        logic       det;
        logic [1:0] din;
        logic       wr;
        logic [2:0] full;
        logic [2:0] empty;
        logic [2:0] exp_we;
        logic       exp_ff;
        logic [2:0] exp_vld;
        logic       exp_err;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; detect_addr = 1'b0; datain = 2'd0; we_reg = 1'b1;
        re = 3'b000; empty = 3'b010; full = 3'b111;
        d5_detect = 1'b0; d5_datain = 3'd0; d5_we_reg = 1'b0;
        d5_re = 5'b00000; d5_empty = 5'b11111; d5_full = 5'b00000;

        vecs[0]  = '{1'b0, 2'd0, 1'b1, 3'b111, 3'b111, 3'b000, 1'b0, 3'b000, 1'b0};
        vecs[1]  = '{1'b1, 2'd1, 1'b1, 3'b111, 3'b111, 3'b000, 1'b0, 3'b000, 1'b0};
        vecs[2]  = '{1'b0, 2'd0, 1'b1, 3'b110, 3'b110, 3'b010, 1'b1, 3'b001, 1'b0};
        vecs[3]  = '{1'b0, 2'd0, 1'b1, 3'b100, 3'b011, 3'b010, 1'b0, 3'b100, 1'b0};
        vecs[4]  = '{1'b0, 2'd0, 1'b0, 3'b010, 3'b101, 3'b000, 1'b1, 3'b010, 1'b0};
        vecs[5]  = '{1'b1, 2'd2, 1'b1, 3'b010, 3'b101, 3'b010, 1'b1, 3'b010, 1'b0};
        vecs[6]  = '{1'b0, 2'd0, 1'b1, 3'b100, 3'b000, 3'b100, 1'b1, 3'b111, 1'b0};
        vecs[7]  = '{1'b1, 2'd3, 1'b1, 3'b100, 3'b000, 3'b100, 1'b1, 3'b111, 1'b0};
        vecs[8]  = '{1'b0, 2'd0, 1'b1, 3'b111, 3'b111, 3'b000, 1'b0, 3'b000, CHK};
        vecs[9]  = '{1'b1, 2'd0, 1'b1, 3'b111, 3'b111, 3'b000, 1'b0, 3'b000, CHK};
        vecs[10] = '{1'b0, 2'd0, 1'b1, 3'b001, 3'b111, 3'b001, 1'b1, 3'b000, 1'b0};

        // Reset state; vld_out follows empty while reset is held
        #1;
        chk("rst_vld", 32'(vld_out), 32'(3'b101));
        chk("rst_we", 32'(we), 32'(3'b000));
        chk("rst_ff", 32'(fifo_full), 32'(1'b0));
        chk("rst_sr", 32'(soft_reset), 32'(3'b000));
        chk("rst_err", 32'(addr_err), 32'(1'b0));
        step();
        reset = 1'b0;

        // Address latch, write steering and full reporting
        for (int i = 0; i < 11; i++) begin
            detect_addr = vecs[i].det;
            datain      = vecs[i].din;
            we_reg      = vecs[i].wr;
            full        = vecs[i].full;
            empty       = vecs[i].empty;
            #1;
            chk($sformatf("tbl%0d_we", i), 32'(we), 32'(vecs[i].exp_we));
            chk($sformatf("tbl%0d_ff", i), 32'(fifo_full), 32'(vecs[i].exp_ff));
            chk($sformatf("tbl%0d_vld", i), 32'(vld_out), 32'(vecs[i].exp_vld));
            chk($sformatf("tbl%0d_err", i), 32'(addr_err), 32'(vecs[i].exp_err));
            chk($sformatf("tbl%0d_sr", i), 32'(soft_reset), 32'(3'b000));
            step();
        end
        detect_addr = 1'b0; we_reg = 1'b0;

        // Channel 0 stalled: pulses after the 30th and 60th edge
        reset = 1'b1; empty = 3'b110; re = 3'b000;
        step();
        reset = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            step();
            chk($sformatf("to_a%0d", k), 32'(soft_reset),
                32'((k == 30 || k == 60) ? 3'b001 : 3'b000));
        end
        // A read on the 16th edge restarts the count: next pulse 30 edges later
        for (int k = 1; k <= 50; k++) begin
            re = (k == 16) ? 3'b001 : 3'b000;
            step();
            chk($sformatf("to_re%0d", k), 32'(soft_reset),
                32'((k == 46) ? 3'b001 : 3'b000));
        end
        re = 3'b000;

        // All channels stalled together
        reset = 1'b1; empty = 3'b000;
        step();
        reset = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            step();
            chk($sformatf("to_all%0d", k), 32'(soft_reset),
                32'((k == 30) ? 3'b111 : 3'b000));
        end
        reset = 1'b1;
        #1;
        chk("rst_drop_sr", 32'(soft_reset), 32'(3'b000));
        #1;
        reset = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
        end
        // Reset at cycle 20 clears counters before they expire
        reset = 1'b1;
        #2;
        reset = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            step();
            chk($sformatf("to_rst%0d", k), 32'(soft_reset),
                32'((k == 30) ? 3'b111 : 3'b000));
        end
        empty = 3'b111;

`ifdef SYNC_ADDR_CHECK_EN
        // Illegal address flags an error and blocks writes until a legal one
        detect_addr = 1'b1; datain = 2'd3; we_reg = 1'b0;
        step();
        detect_addr = 1'b0; we_reg = 1'b1; full = 3'b111;
        #1;
        chk("err_set", 32'(addr_err), 32'(1'b1));
        chk("err_we", 32'(we), 32'(3'b000));
        chk("err_ff", 32'(fifo_full), 32'(1'b0));
        detect_addr = 1'b1; datain = 2'd2;
        step();
        detect_addr = 1'b0;
        #1;
        chk("err_clr", 32'(addr_err), 32'(1'b0));
        chk("err_clr_we", 32'(we), 32'(3'b100));
        we_reg = 1'b0;
`endif

        // Five-channel build: address 4 and a TIMEOUT of 4
        reset = 1'b1;
        step();
        reset = 1'b0;
        d5_detect = 1'b1; d5_datain = 3'd4; d5_we_reg = 1'b1; d5_empty = 5'b01111;
        #1;
        chk("n5_pre_we", 32'(d5_we), 32'(5'b00000));
        step();
        d5_detect = 1'b0; d5_full = 5'b10000;
        #1;
        chk("n5_we", 32'(d5_we), 32'(5'b10000));
        chk("n5_ff", 32'(d5_fifo_full), 32'(1'b1));
        chk("n5_vld", 32'(d5_vld_out), 32'(5'b10000));
        chk("n5_err", 32'(d5_addr_err), 32'(1'b0));
        chk("n5_sr1", 32'(d5_soft_reset), 32'(5'b00000));
        for (int k = 2; k <= 12; k++) begin
            step();
            chk($sformatf("n5_sr%0d", k), 32'(d5_soft_reset),
                32'((k % 4 == 0) ? 5'b10000 : 5'b00000));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/router_sync_n.md
# router_sync_n

Parametrised synchroniser between the router's packet FSM and its NUM_CH output FIFOs. It latches the destination address at packet start and steers the FSM write enable to the one-hot FIFO write strobe. It reports the addressed FIFO's full status and drives per-channel valid-out. Per-channel timeout counters issue a one-cycle soft reset to any FIFO whose valid data sits unread for TIMEOUT cycles. Generalises the fixed 3-channel synchroniser to any channel count and timeout, adds an address-valid qualifier and optional illegal-address detection.

## Interface
- NUM_CH, 3, number of output channels/FIFOs (2..16)
- ADDR_W, 2, width of datain address field; must satisfy 2**ADDR_W >= NUM_CH
- TIMEOUT, 30, unread-valid cycles before soft reset (2..255)
- CNT_W, 8, timeout counter width; must satisfy 2**CNT_W > TIMEOUT
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  reset, asynchronous, active-high
- detect_addr  in  1  header cycle strobe from FSM; latch datain
- datain  in  ADDR_W  destination address (header low bits)
- we_reg  in  1  FSM write request for current packet
- re  in  NUM_CH  per-FIFO read enable from downstream
- empty  in  NUM_CH  per-FIFO empty
- full  in  NUM_CH  per-FIFO full
- fifo_full  out  1  full status of addressed FIFO
- we  out  NUM_CH  one-hot FIFO write strobe
- vld_out  out  NUM_CH  per-channel valid data available
- soft_reset  out  NUM_CH  per-FIFO soft reset pulse
- addr_err  out  1  latched address out of range (see Configuration)

## Operation
- Address register addr_q (ADDR_W) and flag addr_vld_q. On rising edge with detect_addr=1: addr_q <= datain, addr_vld_q <= 1. Otherwise hold.
- we[i] = we_reg & addr_vld_q & (addr_q == i) & ~addr_err; combinational. At most one bit set.
- fifo_full = addr_vld_q & (addr_q < NUM_CH) & full[addr_q]; 0 for illegal address.
- vld_out[i] = ~empty[i]; combinational, no latency.
- Per-channel timeout counter cnt[i] (CNT_W) and registered soft_reset[i], every edge:
  - ~vld_out[i] | re[i]: cnt <= 0, soft_reset <= 0.
  - else if cnt == TIMEOUT-1: cnt <= 0, soft_reset <= 1.
  - else: cnt <= cnt+1, soft_reset <= 0.
- Channels are independent; several soft_reset bits may assert in the same cycle.
- Counters never wrap past TIMEOUT-1; a still-stalled channel re-pulses every TIMEOUT cycles.

## Timing
- Reset values: addr_q=0, addr_vld_q=0, all cnt=0, soft_reset=0, addr_err=0. Hence we=0 and fifo_full=0 until first detect_addr. vld_out follows empty even during reset.
- Reset mid-operation clears counters and address immediately (asynchronous); any pending soft_reset is dropped.
- Address latency: one edge. we_reg in the same cycle as detect_addr uses the previous addr_q. The FSM asserts we_reg no earlier than the cycle after detect_addr.
- detect_addr while we_reg active: new address takes effect after the edge; the write in that cycle goes to the old channel.
- Soft reset: with empty[i]=0 and re[i]=0 sampled at TIMEOUT consecutive edges, soft_reset[i] is high for exactly the cycle after the TIMEOUT-th edge. re[i]=1 on any sampled edge restarts the count.
- empty[i] rising and re[i] in the same cycle both clear; no conflict.

## Configuration
- SYNC_ADDR_CHECK_EN defined: on detect_addr edge, addr_err <= (datain >= NUM_CH). While addr_err=1, we=0 and fifo_full=0. Cleared by the next legal detect_addr or reset.
- Not defined: addr_err tied 0. An out-of-range address yields we=0 and fifo_full=0 by decode; no flag.

## Test plan
- Reset then no detect_addr, we_reg=1 -> we=000, fifo_full=0, soft_reset=000.
- detect_addr=1, datain=01, next cycle we_reg=1, full=110 -> we=010, fifo_full=1; full=100 -> fifo_full=0.
- empty=110 (ch0 valid), re=000 held 30 cycles -> vld_out=001, soft_reset=001 for one cycle after 30th edge, repeats 30 later; re0=1 at cycle 15 -> no pulse until 30 cycles after.
- empty=000, re=000 from same edge -> soft_reset=111 in the same cycle; reset asserted at cycle 20 -> no pulse, counters restart.
- SYNC_ADDR_CHECK_EN set, NUM_CH=3, datain=11 -> addr_err=1, we=000 with we_reg=1; following datain=10 -> addr_err=0, we=100.
- NUM_CH=5, ADDR_W=3, TIMEOUT=4 -> address 4 gives we=10000; stalled ch4 pulses soft_reset[4] every 4 cycles.
